// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station: opcode encodings, default widths,
// a constant clog2 helper and the default-width entry layout used by decode.
package rs_pkg;

  localparam int unsigned RS_OP_W   = 4;
  localparam int unsigned RS_TAG_W  = 3;
  localparam int unsigned RS_DATA_W = 32;

  typedef enum logic [RS_OP_W-1:0] {
    RS_OP_ADD = 4'd0,
    RS_OP_LW  = 4'd1,
    RS_OP_SW  = 4'd2,
    RS_OP_BNE = 4'd3
  } rs_op_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  rob;
    logic                 q1_busy;
    logic [RS_TAG_W-1:0]  q1;
    logic [RS_DATA_W-1:0] v1;
    logic                 q2_busy;
    logic [RS_TAG_W-1:0]  q2;
    logic [RS_DATA_W-1:0] v2;
    logic [RS_DATA_W-1:0] imm;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: grants the ready entry that is older than every other ready entry.
module rs_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready_i,
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        any_o
);

  logic [DEPTH-1:0] blocked;

  always_comb begin
    grant_o = '0;
    blocked = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Any other ready entry that row i is not older than blocks entry i.
      blocked    = ready_i & ~older_i[i];
      blocked[i] = 1'b0;
      grant_o[i] = ready_i[i] & ~(|blocked);
    end
  end

  assign any_o = |ready_i;

endmodule

// File: rtl/reservation_station.sv
// Parametrised reservation station: CDB wakeup, issue bypass, age-ordered dispatch.
// Optional synchronous flush port enabled by defining RS_FLUSH_EN.
module reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = RS_DATA_W,
  parameter int unsigned TAG_W   = RS_TAG_W,
  parameter int unsigned OP_W    = RS_OP_W,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [OP_W-1:0]           issue_op,
  input  logic [TAG_W-1:0]          issue_rob,
  input  logic                      issue_q1_busy,
  input  logic [TAG_W-1:0]          issue_q1,
  input  logic [DATA_W-1:0]         issue_v1,
  input  logic                      issue_q2_busy,
  input  logic [TAG_W-1:0]          issue_q2,
  input  logic [DATA_W-1:0]         issue_v2,
  input  logic [DATA_W-1:0]         issue_imm,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [OP_W-1:0]           disp_op,
  output logic [TAG_W-1:0]          disp_rob,
  output logic [DATA_W-1:0]         disp_v1,
  output logic [DATA_W-1:0]         disp_v2,
  output logic [DATA_W-1:0]         disp_imm,
  output logic [clog2(DEPTH+1)-1:0] count
`ifdef RS_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned IDX_W = clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob;
    logic              q1_busy;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] v1;
    logic              q2_busy;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
  } entry_t;

  logic [DEPTH-1:0]            valid_q, valid_d;
  entry_t                      ent_q [DEPTH];
  entry_t                      ent_d [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        lock_q, lock_d;
  logic [DEPTH-1:0]            hold_q, hold_d;

  logic [DEPTH-1:0] ready, grant, sel;
  logic             any_ready, flush_w, issue_fire, disp_fire, free_found;
  logic [IDX_W-1:0] free_idx;
  entry_t           new_ent;

`ifdef RS_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Returns {busy, value} after snooping all buses; lowest-numbered matching bus wins.
  function automatic logic [DATA_W:0] snoop(
    input logic                      busy,
    input logic [TAG_W-1:0]          q,
    input logic [DATA_W-1:0]         v,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*TAG_W-1:0]  ct,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic              hit;
    logic [DATA_W-1:0] val;
    hit = 1'b0;
    val = v;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (busy && !hit && cv[k] && (ct[k*TAG_W +: TAG_W] == q)) begin
        hit = 1'b1;
        val = cd[k*DATA_W +: DATA_W];
      end
    end
    return {busy & ~hit, val};
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] & ~ent_q[i].q1_busy & ~ent_q[i].q2_busy;
    end
  end

  rs_select #(
    .DEPTH(DEPTH)
  ) u_select (
    .ready_i (ready),
    .older_i (older_q),
    .grant_o (grant),
    .any_o   (any_ready)
  );

  // A stalled dispatch keeps its choice until accepted, so a newly ready older entry cannot preempt it.
  assign sel         = lock_q ? hold_q : grant;
  assign disp_valid  = lock_q | any_ready;
  assign issue_ready = (count_q < CNT_W'(DEPTH));
  assign issue_fire  = issue_valid & issue_ready & ~flush_w;
  assign disp_fire   = disp_valid & disp_ready & ~flush_w;
  assign count       = count_q;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    new_ent     = '0;
    new_ent.op  = issue_op;
    new_ent.rob = issue_rob;
    new_ent.q1  = issue_q1;
    new_ent.q2  = issue_q2;
    new_ent.imm = issue_imm;
    {new_ent.q1_busy, new_ent.v1} = snoop(issue_q1_busy, issue_q1, issue_v1, cdb_valid, cdb_tag, cdb_data);
    {new_ent.q2_busy, new_ent.v2} = snoop(issue_q2_busy, issue_q2, issue_v2, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    disp_op  = '0;
    disp_rob = '0;
    disp_v1  = '0;
    disp_v2  = '0;
    disp_imm = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        disp_op  = disp_op  | ent_q[i].op;
        disp_rob = disp_rob | ent_q[i].rob;
        disp_v1  = disp_v1  | ent_q[i].v1;
        disp_v2  = disp_v2  | ent_q[i].v2;
        disp_imm = disp_imm | ent_q[i].imm;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    older_d = older_q;
    count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);
    lock_d  = disp_valid & ~disp_ready & ~flush_w;
    hold_d  = sel;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        {ent_d[i].q1_busy, ent_d[i].v1} = snoop(ent_q[i].q1_busy, ent_q[i].q1, ent_q[i].v1, cdb_valid, cdb_tag, cdb_data);
        {ent_d[i].q2_busy, ent_d[i].v2} = snoop(ent_q[i].q2_busy, ent_q[i].q2, ent_q[i].v2, cdb_valid, cdb_tag, cdb_data);
      end
    end

    if (disp_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sel[i]) begin
          valid_d[i] = 1'b0;
          older_d[i] = '0;
          for (int unsigned r = 0; r < DEPTH; r++) older_d[r][i] = 1'b0;
        end
      end
    end

    // Column uses post-dispatch validity so an entry leaving this cycle is not recorded as older.
    if (issue_fire) begin
      older_d[free_idx] = '0;
      for (int unsigned r = 0; r < DEPTH; r++) older_d[r][free_idx] = valid_d[r];
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = new_ent;
    end

    if (flush_w) begin
      valid_d = '0;
      older_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      older_q <= '0;
      count_q <= '0;
      lock_q  <= 1'b0;
      hold_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
      lock_q  <= lock_d;
      hold_q  <= hold_d;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios then random traffic,
// all checked against an age-ordered queue model. Exercises flush when RS_FLUSH_EN is defined.
module tb_reservation_station;
  import rs_pkg::*;

  localparam int DEPTH = 4, DATA_W = 32, TAG_W = 3, OP_W = 4, NUM_CDB = 2;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic                      issue_valid, issue_ready;
  logic [OP_W-1:0]           issue_op;
  logic [TAG_W-1:0]          issue_rob, issue_q1, issue_q2;
  logic                      issue_q1_busy, issue_q2_busy;
  logic [DATA_W-1:0]         issue_v1, issue_v2, issue_imm;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      disp_valid, disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [TAG_W-1:0]          disp_rob;
  logic [DATA_W-1:0]         disp_v1, disp_v2, disp_imm;
  logic [2:0]                count;
`ifdef RS_FLUSH_EN
  logic                      flush;
`endif

  always #5 clock = ~clock;

  reservation_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op), .issue_rob(issue_rob),
    .issue_q1_busy(issue_q1_busy), .issue_q1(issue_q1), .issue_v1(issue_v1),
    .issue_q2_busy(issue_q2_busy), .issue_q2(issue_q2), .issue_v2(issue_v2), .issue_imm(issue_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_rob(disp_rob), .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_imm(disp_imm),
    .count(count)
`ifdef RS_FLUSH_EN
    , .flush(flush)
`endif
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue kept oldest-first; an entry is ready when neither operand waits.
  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [2:0]  rob;
    bit          b1;
    logic [2:0]  q1;
    logic [31:0] v1;
    bit          b2;
    logic [2:0]  q2;
    logic [31:0] v2;
    logic [31:0] imm;
  } m_ent_t;

  m_ent_t mq[$];
  int     held_id = -1;
  int     next_id = 0;

  function automatic void wake_op(inout bit b, input logic [2:0] q, inout logic [31:0] v);
    if (!b) return;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q) begin
        b = 1'b0;
        v = cdb_data[k*DATA_W +: DATA_W];
        return;
      end
    end
  endfunction

  function automatic int model_sel();
    if (held_id >= 0) begin
      foreach (mq[i]) if (mq[i].id == held_id) return i;
      return -1;
    end
    foreach (mq[i]) if (!mq[i].b1 && !mq[i].b2) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int     s;
    bit     fl, dv, fire_d, fire_i;
    int     new_held;
    m_ent_t e;
    fl = 1'b0;
`ifdef RS_FLUSH_EN
    fl = flush;
`endif
    s        = model_sel();
    dv       = (s >= 0);
    fire_d   = dv && disp_ready && !fl;
    fire_i   = issue_valid && (mq.size() < DEPTH) && !fl;
    if (fl) begin
      mq.delete();
      held_id = -1;
      return;
    end
    new_held = (dv && !disp_ready) ? mq[s].id : -1;
    foreach (mq[i]) begin
      wake_op(mq[i].b1, mq[i].q1, mq[i].v1);
      wake_op(mq[i].b2, mq[i].q2, mq[i].v2);
    end
    if (fire_d) mq.delete(s);
    if (fire_i) begin
      e.id = next_id++;
      e.op = issue_op;  e.rob = issue_rob; e.imm = issue_imm;
      e.b1 = issue_q1_busy; e.q1 = issue_q1; e.v1 = issue_v1;
      e.b2 = issue_q2_busy; e.q2 = issue_q2; e.v2 = issue_v2;
      wake_op(e.b1, e.q1, e.v1);
      wake_op(e.b2, e.q2, e.v2);
      mq.push_back(e);
    end
    held_id = new_held;
  endtask

  task automatic compare_model();
    int s;
    s = model_sel();
    chk("count", 32'(count), mq.size());
    chk("issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
    chk("disp_valid", 32'(disp_valid), 32'(s >= 0));
    if (s >= 0) begin
      chk("disp_op", 32'(disp_op), 32'(mq[s].op));
      chk("disp_rob", 32'(disp_rob), 32'(mq[s].rob));
      chk("disp_v1", disp_v1, mq[s].v1);
      chk("disp_v2", disp_v2, mq[s].v2);
      chk("disp_imm", disp_imm, mq[s].imm);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_model();
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [2:0] rob,
                             input bit b1, input logic [2:0] q1, input logic [31:0] v1,
                             input bit b2, input logic [2:0] q2, input logic [31:0] v2,
                             input logic [31:0] imm);
    issue_valid = 1'b1; issue_op = op; issue_rob = rob; issue_imm = imm;
    issue_q1_busy = b1; issue_q1 = q1; issue_v1 = v1;
    issue_q2_busy = b2; issue_q2 = q2; issue_v2 = v2;
  endtask

  task automatic drive_cdb(input int k, input logic [2:0] tag, input logic [31:0] data);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*TAG_W +: TAG_W] = tag;
    cdb_data[k*DATA_W +: DATA_W] = data;
  endtask

  task automatic quiet();
    issue_valid = 1'b0;
    cdb_valid   = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    quiet();
    issue_op = '0; issue_rob = '0; issue_imm = '0;
    issue_q1_busy = 1'b0; issue_q1 = '0; issue_v1 = '0;
    issue_q2_busy = 1'b0; issue_q2 = '0; issue_v2 = '0;
    cdb_tag = '0; cdb_data = '0; disp_ready = 1'b0;
`ifdef RS_FLUSH_EN
    flush = 1'b0;
`endif
    #3;
    chk("reset_count", 32'(count), 0);
    chk("reset_issue_ready", 32'(issue_ready), 1);
    chk("reset_disp_valid", 32'(disp_valid), 0);
    chk("reset_disp_v1", disp_v1, 0);
    chk("reset_disp_rob", 32'(disp_rob), 0);
    #9 reset_n = 1'b1;
    @(negedge clock);

    // Both operands ready: dispatched the cycle after issue.
    disp_ready = 1'b1;
    drive_issue(RS_OP_ADD, 3'd2, 0, 3'd0, 32'd5, 0, 3'd0, 32'd7, 32'd0);
    tick(); quiet();
    chk("ready_issue_dv", 32'(disp_valid), 1);
    chk("ready_issue_v1", disp_v1, 5);
    chk("ready_issue_v2", disp_v2, 7);
    chk("ready_issue_rob", 32'(disp_rob), 2);
    tick();
    chk("ready_issue_drained", 32'(count), 0);

    // Operand 1 woken by CDB1 two cycles after issue.
    drive_issue(RS_OP_LW, 3'd4, 1, 3'd3, 32'd0, 0, 3'd0, 32'd9, 32'h10);
    tick(); quiet();
    tick();
    chk("wake_before_dv", 32'(disp_valid), 0);
    drive_cdb(1, 3'd3, 32'h1234);
    tick(); quiet();
    chk("wake_after_dv", 32'(disp_valid), 1);
    chk("wake_after_v1", disp_v1, 32'h1234);
    tick();

    // Issue-cycle bypass from CDB0.
    drive_issue(RS_OP_SW, 3'd6, 0, 3'd0, 32'd1, 1, 3'd5, 32'd0, 32'h4);
    drive_cdb(0, 3'd5, 32'hAA);
    tick(); quiet();
    chk("bypass_dv", 32'(disp_valid), 1);
    chk("bypass_v2", disp_v2, 32'hAA);
    tick();
    chk("bypass_drained", 32'(count), 0);

    // Age order and hold: A,B,C waiting; wake C and A together.
    disp_ready = 1'b0;
    drive_issue(RS_OP_ADD, 3'd1, 1, 3'd5, 0, 0, 0, 32'd11, 0); tick();
    drive_issue(RS_OP_ADD, 3'd2, 1, 3'd6, 0, 0, 0, 32'd12, 0); tick();
    drive_issue(RS_OP_ADD, 3'd3, 1, 3'd7, 0, 0, 0, 32'd13, 0); tick(); quiet();
    chk("age_wait_dv", 32'(disp_valid), 0);
    drive_cdb(0, 3'd7, 32'h333);
    drive_cdb(1, 3'd5, 32'h111);
    tick(); quiet();
    chk("age_sel_a", 32'(disp_rob), 1);
    tick();
    chk("age_hold_a", 32'(disp_rob), 1);
    chk("age_hold_a_v1", disp_v1, 32'h111);
    disp_ready = 1'b1;
    tick();
    chk("age_then_c", 32'(disp_rob), 3);
    tick();
    // Younger D held while older B wakes: no preemption.
    disp_ready = 1'b0;
    drive_issue(RS_OP_BNE, 3'd4, 0, 0, 32'd44, 0, 0, 32'd45, 32'd8);
    tick(); quiet();
    chk("hold_sel_d", 32'(disp_rob), 4);
    drive_cdb(0, 3'd6, 32'h222);
    tick(); quiet();
    chk("hold_no_preempt", 32'(disp_rob), 4);
    disp_ready = 1'b1;
    tick();
    chk("hold_then_b", 32'(disp_rob), 2);
    tick();
    chk("hold_drained", 32'(count), 0);

    // Full station: fifth issue refused.
    disp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_issue(RS_OP_LW, 3'(i), 1, 3'd0, 0, 0, 0, 32'(i), 0);
      tick();
    end
    chk("full_count", 32'(count), 4);
    chk("full_issue_ready", 32'(issue_ready), 0);
    drive_issue(RS_OP_LW, 3'd5, 0, 0, 0, 0, 0, 0, 0);
    tick(); quiet();
    chk("full_fifth_refused", 32'(count), 4);
`ifdef RS_FLUSH_EN
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(count), 0);
`else
    drive_cdb(0, 3'd0, 32'h5);
    tick(); quiet();
    disp_ready = 1'b1;
    repeat (5) tick();
    chk("full_drained", 32'(count), 0);
`endif

    // Asynchronous reset between edges with three entries held.
    disp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(RS_OP_ADD, 3'(i + 1), 1, 3'd2, 0, 1, 3'd3, 0, 0);
      tick();
    end
    quiet();
    chk("pre_reset_count", 32'(count), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_count", 32'(count), 0);
    chk("async_reset_dv", 32'(disp_valid), 0);
    chk("async_reset_ir", 32'(issue_ready), 1);
    mq.delete();
    held_id = -1;
    #1 reset_n = 1'b1;
    @(negedge clock);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      issue_valid   = ($urandom_range(0, 2) != 0);
      issue_op      = 4'($urandom_range(0, 3));
      issue_rob     = 3'($urandom);
      issue_q1_busy = $urandom_range(0, 1) == 1;
      issue_q1      = 3'($urandom);
      issue_v1      = $urandom;
      issue_q2_busy = $urandom_range(0, 1) == 1;
      issue_q2      = 3'($urandom);
      issue_v2      = $urandom;
      issue_imm     = $urandom;
      cdb_valid[0]  = ($urandom_range(0, 2) == 0);
      cdb_valid[1]  = ($urandom_range(0, 2) == 0);
      cdb_tag       = 6'($urandom);
      cdb_data      = {$urandom, $urandom};
      disp_ready    = ($urandom_range(0, 3) != 0);
`ifdef RS_FLUSH_EN
      flush         = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Parametrised out-of-order reservation station. Successor to the fixed per-unit stations (add, load, store, bne).
- Generalised in entry count, tag and data width, and number of snooped CDBs.
- Sits between decode/issue and one functional unit. Holds renamed instructions until both operands arrive over the CDBs, then dispatches the oldest ready entry.
- New over the predecessors: multi-entry storage, oldest-first selection, issue-cycle CDB bypass, valid/ready dispatch handshake, occupancy output.

Parameters:
- DEPTH, 4, number of entries (2..16).
- DATA_W, 32, operand/immediate width.
- TAG_W, 3, ROB index width; the ROB has 2^TAG_W slots.
- OP_W, 4, opcode/subtype field width.
- NUM_CDB, 2, number of snooped broadcast buses.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  free entry exists (count < DEPTH)
- issue_op  in  OP_W  operation code
- issue_rob  in  TAG_W  destination ROB index
- issue_q1_busy  in  1  operand 1 pending (tag in issue_q1)
- issue_q1  in  TAG_W  producer tag, operand 1
- issue_v1  in  DATA_W  value, operand 1 (used when not busy)
- issue_q2_busy, issue_q2, issue_v2  in  1/TAG_W/DATA_W  same for operand 2
- issue_imm  in  DATA_W  offset/immediate
- cdb_valid  in  NUM_CDB  per-bus broadcast strobe
- cdb_tag  in  NUM_CDB*TAG_W  per-bus ROB tag, bus k at [k*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*DATA_W  per-bus result
- disp_valid  out  1  a ready entry is presented
- disp_ready  in  1  functional unit accepts
- disp_op, disp_rob, disp_v1, disp_v2, disp_imm  out  OP_W/TAG_W/DATA_W x3  selected entry
- count  out  clog2(DEPTH+1)  occupied entries
- flush  in  1  present only with RS_FLUSH_EN

Behaviour:
- Reset (async, reset_n low):
  - All entries invalid; age matrix cleared.
  - count=0, issue_ready=1, disp_valid=0. disp_* payload is don't-care, but the RTL drives 0.
- Entry contents: valid, op, rob, q1_busy/q1/v1, q2_busy/q2/v2, imm.
- Issue:
  - Occurs when issue_valid && issue_ready at a rising edge.
  - Writes the lowest-index free entry.
  - issue_ready ignores a same-cycle dispatch, so it is conservative: a full RS with a dispatch in flight still shows 0.
- Issue bypass: if an operand is busy and any cdb_valid[k] with cdb_tag[k]==q in the same cycle, the entry is written not-busy with cdb_data[k].
- Wakeup: every cycle, each valid busy operand compares against all buses.
  - On a match: capture the data and clear busy at the edge.
  - Multiple matching buses: the lowest k wins. This is a protocol error; the RTL does not assert on it.
- Ready: valid && !q1_busy && !q2_busy, evaluated on registered state. An operand woken at edge t is dispatchable in the cycle after t, with no same-cycle CDB-to-dispatch path.
- Age order: DEPTH x DEPTH matrix, older[i][j]. On issue into j, older[i][j]=valid[i] and older[j][*]=0; rows and columns of freed entries are cleared.
- Select:
  - Picks the ready entry that is older than every other ready entry.
  - disp_valid and disp_* are combinational from registered state.
  - Selection holds stable while disp_valid && !disp_ready; an older entry becoming ready later does not preempt.
- Dispatch: disp_valid && disp_ready at the edge frees the selected entry.
- Simultaneous issue and dispatch: both occur; count unchanged. The issued entry cannot be the one dispatched.
- count: registered, +1 on issue, -1 on dispatch.
- Tags are compared exactly; no wrap arithmetic on TAG_W.

Optional Feature:
- RS_FLUSH_EN defined:
  - flush port exists. flush=1 at an edge invalidates all entries, clears the age matrix and sets count=0.
  - Issue and dispatch in a flush cycle are suppressed; disp_valid is still shown, but its handshake is ignored.
  - The RS accepts issue the next cycle.
- RS_FLUSH_EN undefined: no flush port; entries are cleared only by dispatch or reset.

Decomposition:
- Package rs_pkg:
  - opcode/subtype localparams shared with decode: add, lw, sw, bne.
  - default TAG_W/DATA_W.
  - clog2 function.
  - entry struct typedef.
- Sub-module rs_select: combinational oldest-ready picker from the ready vector and age matrix. Outputs a one-hot grant plus an any-ready flag.
- Wakeup, bypass and storage stay in reservation_station.

Test Plan:
- Reset mid-operation: fill 3 entries, pull reset_n low asynchronously between edges -> count=0, disp_valid=0 immediately; issue_ready=1.
- Issue with both operands ready (op=add, v1=5, v2=7, rob=2), disp_ready=1 -> disp_valid next cycle with v1=5, v2=7, rob=2; count returns to 0 one edge later.
- Issue with q1=3 busy; CDB1 broadcasts tag 3, data 0x1234 two cycles later -> disp_valid rises the cycle after the broadcast edge, disp_v1=0x1234.
- Issue-cycle bypass: issue q2=5 busy while cdb_valid[0] with tag 5, data 0xAA -> entry ready immediately; dispatched next cycle with v2=0xAA.
- Age order: issue A(rob1), B(rob2), C(rob3), all waiting; wake C, then A in the same cycle -> dispatch A then C; while disp_ready=0, selection holds A.
- Full RS: DEPTH=4, 4 issues with no wakeup -> issue_ready=0, count=4; a fifth issue_valid is not accepted. Under RS_FLUSH_EN, flush -> count=0 next cycle.
